direction_ctrl: RTL and testbench

DIRECTION_CTRL -- requirements
Module: direction_ctrl

---
 rtl/direction_ctrl_pkg.sv | 23 ++
 rtl/direction_ctrl_key_debounce.sv | 65 ++++++
 rtl/direction_ctrl.sv | 94 +++++++++
 tb/tb_direction_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/direction_ctrl_pkg.sv
// Shared heading encodings and key index constants used by the steering block
// and the snake datapath.
package direction_ctrl_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    localparam int unsigned KEY_RIGHT = 0;
    localparam int unsigned KEY_DOWN  = 1;
    localparam int unsigned KEY_UP    = 2;
    localparam int unsigned KEY_LEFT  = 3;
    localparam int unsigned NUM_KEYS  = 4;

    // Right/left share one axis (bits equal), up/down the other (bits differ).
    function automatic logic dir_vertical(input dir_e d);
        return d[1] ^ d[0];
    endfunction

endpackage

// File: rtl/direction_ctrl_key_debounce.sv
// One push-button: 2-flop synchronizer, counter debounce and press-edge pulse.
// A key held through reset stays ignored until seen released long enough.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press_edge
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [1:0]    fill_q, fill_d;
    logic          level_q, level_d;
    logic          armed_q, armed_d;
    logic          edge_q, edge_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d  = {sync_q[0], key_n};
        fill_d  = {fill_q[0], 1'b1};
        level_d = level_q;
        armed_d = armed_q;
        edge_d  = 1'b0;
        cnt_d   = '0;
        // Disarmed: count consecutive genuine released samples before trusting the key.
        if (!armed_q) begin
            if (fill_q[1] && sync_q[1]) begin
                if (cnt_q >= CNT_LAST) armed_d = 1'b1;
                else                   cnt_d   = cnt_q + 1'b1;
            end
        end else if (sync_q[1] != level_q) begin
            if (cnt_q >= CNT_LAST) begin
                level_d = sync_q[1];
                edge_d  = !sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            fill_q  <= '0;
            level_q <= 1'b1;
            armed_q <= 1'b0;
            edge_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            level_q <= level_d;
            armed_q <= armed_d;
            edge_q  <= edge_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_edge = edge_q;

endmodule

// File: rtl/direction_ctrl.sv
// Snake steering: debounced key presses become turn requests, held in a
// single-entry pending slot and applied to the heading on the game tick.
module direction_ctrl
    import direction_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic       tick,
    output logic [1:0] dir,
    output logic       move_right,
    output logic       move_down,
    output logic       move_up,
    output logic       move_left,
    output logic       turn_applied,
    output logic       pending_valid
);

    logic [NUM_KEYS-1:0] press;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk        (clk),
            .reset      (reset),
            .key_n      (key_n[i]),
            .press_edge (press[i])
        );
    end

    dir_e dir_q, dir_d;
    dir_e pend_dir_q, pend_dir_d;
    logic pend_valid_q, pend_valid_d;
    logic turn_q, turn_d;
    dir_e req_dir;
    logic req_valid;
    logic req_accept;

    always_comb begin
        req_valid = 1'b1;
        req_dir   = DIR_RIGHT;
        if      (press[KEY_UP])    req_dir = DIR_UP;
        else if (press[KEY_DOWN])  req_dir = DIR_DOWN;
        else if (press[KEY_LEFT])  req_dir = DIR_LEFT;
        else if (press[KEY_RIGHT]) req_dir = DIR_RIGHT;
        else                       req_valid = 1'b0;
        req_accept = req_valid && (dir_vertical(req_dir) != dir_vertical(dir_q));
    end

    always_comb begin
        dir_d        = dir_q;
        pend_dir_d   = pend_dir_q;
        pend_valid_d = pend_valid_q;
        turn_d       = 1'b0;
        // A stored turn beats a request arriving on the same tick.
        if (tick) begin
            if (pend_valid_q) begin
                dir_d        = pend_dir_q;
                pend_valid_d = 1'b0;
                turn_d       = 1'b1;
            end else if (req_accept) begin
                dir_d  = req_dir;
                turn_d = 1'b1;
            end
        end else if (req_accept) begin
            pend_dir_d   = req_dir;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q        <= DIR_RIGHT;
            pend_dir_q   <= DIR_RIGHT;
            pend_valid_q <= 1'b0;
            turn_q       <= 1'b0;
        end else begin
            dir_q        <= dir_d;
            pend_dir_q   <= pend_dir_d;
            pend_valid_q <= pend_valid_d;
            turn_q       <= turn_d;
        end
    end

    assign dir           = dir_q;
    assign move_right    = (dir_q == DIR_RIGHT);
    assign move_down     = (dir_q == DIR_DOWN);
    assign move_up       = (dir_q == DIR_UP);
    assign move_left     = (dir_q == DIR_LEFT);
    assign turn_applied  = turn_q;
    assign pending_valid = pend_valid_q;

endmodule

// File: tb/tb_direction_ctrl.sv
// Directed bench for direction_ctrl with a short debounce window.
module tb_direction_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic       tick;
    logic [1:0] dir;
    logic       move_right, move_down, move_up, move_left;
    logic       turn_applied, pending_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int turn_cnt = 0;
    int turn_ref;

    direction_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .key_n         (key_n),
        .tick          (tick),
        .dir           (dir),
        .move_right    (move_right),
        .move_down     (move_down),
        .move_up       (move_up),
        .move_left     (move_left),
        .turn_applied  (turn_applied),
        .pending_valid (pending_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (turn_applied === 1'b1) turn_cnt++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dir(input string tag, input logic [1:0] exp);
        logic [3:0] oh;
        oh = 4'b0001 << exp;
        check(tag, {30'd0, dir}, {30'd0, exp});
        check({tag, "_onehot"}, {28'd0, move_left, move_up, move_down, move_right}, {28'd0, oh});
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic press_release(input int k, input int hold);
        key_n[k] = 1'b0;
        step(hold);
        key_n[k] = 1'b1;
        step(8);
    endtask

    initial begin
        reset = 1'b1;
        key_n = 4'hF;
        tick  = 1'b0;
        step(3);
        check_dir("reset_dir", 2'b00);
        check("reset_pending", {31'd0, pending_valid}, 32'd0);
        check("reset_turn", {31'd0, turn_applied}, 32'd0);
        reset = 1'b0;

        // Idle with periodic ticks
        turn_ref = turn_cnt;
        for (int c = 0; c < 20; c++) begin
            tick = (c % 5 == 4);
            step(1);
        end
        tick = 1'b0;
        check_dir("idle_dir", 2'b00);
        check("idle_turns", turn_cnt - turn_ref, 32'd0);

        // Left while heading right: same axis, discarded
        key_n[3] = 1'b0;
        step(10);
        check("left_rev_pending", {31'd0, pending_valid}, 32'd0);
        key_n[3] = 1'b1;
        step(8);
        tick_pulse();
        check_dir("left_rev_dir", 2'b00);
        check("left_rev_turn", {31'd0, turn_applied}, 32'd0);

        // Bouncing down key never settles
        for (int c = 0; c < 5; c++) begin
            key_n[1] = 1'b0;
            step(2);
            key_n[1] = 1'b1;
            step(2);
        end
        step(8);
        check("bounce_pending", {31'd0, pending_valid}, 32'd0);
        tick_pulse();
        check_dir("bounce_dir", 2'b00);

        // Up press, then tick applies it
        turn_ref = turn_cnt;
        key_n[2] = 1'b0;
        step(10);
        check("up_pending", {31'd0, pending_valid}, 32'd1);
        check_dir("up_before_tick", 2'b00);
        key_n[2] = 1'b1;
        tick_pulse();
        check_dir("up_after_tick", 2'b10);
        check("up_turn_pulse", {31'd0, turn_applied}, 32'd1);
        step(1);
        check("up_turn_end", {31'd0, turn_applied}, 32'd0);
        check("up_pending_clr", {31'd0, pending_valid}, 32'd0);
        check("up_turn_count", turn_cnt - turn_ref, 32'd1);
        step(8);

        // Back to right, then up followed by down: last wins
        press_release(0, 8);
        tick_pulse();
        check_dir("to_right", 2'b00);
        press_release(2, 8);
        check("lastwin_pending", {31'd0, pending_valid}, 32'd1);
        press_release(1, 8);
        tick_pulse();
        check_dir("lastwin_dir", 2'b01);

        // Turn left, then up+down together: up has priority
        press_release(3, 8);
        tick_pulse();
        check_dir("to_left", 2'b11);
        key_n[2] = 1'b0;
        key_n[1] = 1'b0;
        step(8);
        key_n = 4'hF;
        step(8);
        tick_pulse();
        check_dir("prio_dir", 2'b10);

        // Request landing on a tick with nothing pending is applied directly
        key_n[0] = 1'b0;
        step(6);
        check("direct_pre_pending", {31'd0, pending_valid}, 32'd0);
        tick_pulse();
        check_dir("direct_dir", 2'b00);
        check("direct_turn", {31'd0, turn_applied}, 32'd1);
        check("direct_pending", {31'd0, pending_valid}, 32'd0);
        key_n[0] = 1'b1;
        step(8);

        // Pending up plus new down on the tick: pending wins, new discarded
        press_release(2, 8);
        key_n[1] = 1'b0;
        step(6);
        tick_pulse();
        check_dir("collide_dir", 2'b10);
        check("collide_pending", {31'd0, pending_valid}, 32'd0);
        key_n[1] = 1'b1;
        step(8);
        tick_pulse();
        check_dir("collide_next", 2'b10);
        check("collide_next_turn", {31'd0, turn_applied}, 32'd0);

        // Reset with a pending request and the key still held
        press_release(0, 8);
        tick_pulse();
        check_dir("pre_rst_right", 2'b00);
        key_n[2] = 1'b0;
        step(8);
        check("pre_rst_pending", {31'd0, pending_valid}, 32'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst_pending", {31'd0, pending_valid}, 32'd0);
        step(12);
        tick_pulse();
        check_dir("held_dir", 2'b00);
        check("held_pending", {31'd0, pending_valid}, 32'd0);
        key_n[2] = 1'b1;
        step(12);
        press_release(2, 8);
        check("repress_pending", {31'd0, pending_valid}, 32'd1);
        tick_pulse();
        check_dir("repress_dir", 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
